ob_cmd_scheduler: RTL

Command scheduler in the `clk_engine` domain. It sits between the order sources and the order book engine. It arbitrates two 32-bit order streams: network orders from the RX CDC FIFO and bot orders from the strategy. It also merges book-dump requests into the same stream. Exactly one command is in flight at a time; the next is not issued until the engine reports idle, and a watchdog flags a hung engine.

---
 rtl/ob_pkg.sv | 38 +++
 rtl/ob_rr_arb2.sv | 33 +++
 rtl/ob_cmd_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
// ob_pkg: definitions shared by the order-book command scheduler.
//   - order word field positions {price, is_buy, is_bot, qty}
//   - ob_cmd_op and grant_src encodings
//   - scheduler FSM state encoding
package ob_pkg;

  localparam int PRICE_MSB  = 31;
  localparam int PRICE_LSB  = 16;
  localparam int IS_BUY_BIT = 15;
  localparam int IS_BOT_BIT = 14;
  localparam int QTY_MSB    = 13;
  localparam int QTY_LSB    = 0;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_ORDER = 2'b01,
    OP_DUMP  = 2'b10
  } ob_op_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_NET  = 2'b01,
    SRC_BOT  = 2'b10,
    SRC_DUMP = 2'b11
  } ob_src_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_GUARD     = 2'b10,
    ST_WAIT_DONE = 2'b11
  } ob_state_e;

  function automatic logic qty_is_zero(input logic [31:0] order);
    return (order[QTY_MSB:QTY_LSB] == '0);
  endfunction

endpackage

// File: rtl/ob_rr_arb2.sv
// ob_rr_arb2: two-input round-robin arbiter.
// Ports:
//   clk_engine, rst_engine_n  clock / async active-low reset
//   req_net, req_bot          requests
//   update                    advance the last-grant pointer to the current winner
//   grant_net, grant_bot      one-hot grant (combinational)
module ob_rr_arb2 (
  input  logic clk_engine,
  input  logic rst_engine_n,
  input  logic req_net,
  input  logic req_bot,
  input  logic update,
  output logic grant_net,
  output logic grant_bot
);

  // 1 when bot held the last grant; reset value makes net win the first tie
  logic last_bot;

  always_comb begin
    grant_net = req_net && (!req_bot || last_bot);
    grant_bot = req_bot && (!req_net || !last_bot);
  end

  always_ff @(posedge clk_engine or negedge rst_engine_n) begin
    if (!rst_engine_n) begin
      last_bot <= 1'b1;
    end else if (update) begin
      last_bot <= grant_bot;
    end
  end

endmodule

// File: rtl/ob_cmd_scheduler.sv
// ob_cmd_scheduler: arbitrates network and bot order streams plus book-dump
// requests into a single command stream to the order book engine, one command
// in flight at a time, with a watchdog on engine_busy.
// Ports:
//   clk_engine, rst_engine_n          clock / async active-low reset
//   net_tdata/tvalid/tready           network order stream
//   bot_tdata/tvalid/tready           bot order stream
//   dump_req                          single-cycle dump request
//   ob_cmd_data/op/valid, ob_cmd_ready command to the engine
//   engine_busy                       engine processing indication
//   grant_src                         source of the last issued command
//   timeout_err, clr_err              sticky watchdog flag and its clear
//   order_cnt, drop_cnt               issued orders / discarded zero-qty orders
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | choose pending dump, else pop round-robin winner
// ISSUE     | ob_cmd_valid held until ob_cmd_ready
// GUARD     | one cycle with engine_busy ignored (engine may raise it late)
// WAIT_DONE | wait for engine_busy low, watchdog running
module ob_cmd_scheduler
  import ob_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk_engine,
  input  logic             rst_engine_n,
  input  logic [31:0]      net_tdata,
  input  logic             net_tvalid,
  output logic             net_tready,
  input  logic [31:0]      bot_tdata,
  input  logic             bot_tvalid,
  output logic             bot_tready,
  input  logic             dump_req,
  output logic [31:0]      ob_cmd_data,
  output logic [1:0]       ob_cmd_op,
  output logic             ob_cmd_valid,
  input  logic             ob_cmd_ready,
  input  logic             engine_busy,
  output logic [1:0]       grant_src,
  output logic             timeout_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] order_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  ob_state_e       state;
  ob_src_e         src_hold;
  logic            dump_pend;
  logic [WD_W-1:0] wd_cnt;

  logic        pop_en;
  logic        grant_net;
  logic        grant_bot;
  logic        popped;
  logic [31:0] pop_data;
  logic        dump_take;
  logic        timeout_hit;

  // Popping is only allowed in IDLE with no dump waiting; reset is folded in
  // so both treadys read 0 while reset is asserted.
  assign pop_en = rst_engine_n && (state == ST_IDLE) && !dump_pend;

  ob_rr_arb2 u_arb (
    .clk_engine  (clk_engine),
    .rst_engine_n(rst_engine_n),
    .req_net     (net_tvalid && pop_en),
    .req_bot     (bot_tvalid && pop_en),
    .update      (popped),
    .grant_net   (grant_net),
    .grant_bot   (grant_bot)
  );

  assign net_tready  = grant_net;
  assign bot_tready  = grant_bot;
  assign popped      = grant_net || grant_bot;
  assign pop_data    = grant_bot ? bot_tdata : net_tdata;
  assign dump_take   = (state == ST_IDLE) && dump_pend;
  assign timeout_hit = (state == ST_WAIT_DONE) && engine_busy && (wd_cnt == WD_LAST);

  always_ff @(posedge clk_engine or negedge rst_engine_n) begin
    if (!rst_engine_n) begin
      state        <= ST_IDLE;
      src_hold     <= SRC_NONE;
      dump_pend    <= 1'b0;
      wd_cnt       <= '0;
      ob_cmd_valid <= 1'b0;
      ob_cmd_op    <= OP_NONE;
      ob_cmd_data  <= '0;
      grant_src    <= SRC_NONE;
      timeout_err  <= 1'b0;
      order_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      // a request landing on the consuming cycle re-arms the flag
      dump_pend <= dump_req || (dump_pend && !dump_take);

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (dump_pend) begin
            ob_cmd_valid <= 1'b1;
            ob_cmd_op    <= OP_DUMP;
            ob_cmd_data  <= '0;
            src_hold     <= SRC_DUMP;
            state        <= ST_ISSUE;
          end else if (popped) begin
            if (qty_is_zero(pop_data)) begin
              drop_cnt <= drop_cnt + CNT_W'(1);
            end else begin
              ob_cmd_valid <= 1'b1;
              ob_cmd_op    <= OP_ORDER;
              ob_cmd_data  <= pop_data;
              src_hold     <= grant_bot ? SRC_BOT : SRC_NET;
              state        <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (ob_cmd_ready) begin
            ob_cmd_valid <= 1'b0;
            ob_cmd_op    <= OP_NONE;
            ob_cmd_data  <= '0;
            grant_src    <= src_hold;
            if (ob_cmd_op == OP_ORDER) begin
              order_cnt <= order_cnt + CNT_W'(1);
            end
            state <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          wd_cnt <= '0;
          state  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!engine_busy || timeout_hit) begin
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
